axi_lite_regbank: RTL

- Parametrised AXI4-Lite slave register bank; next generation of the fixed 4 x 32-bit slave register IP.
- Generalised in register count and data width.
- Adds per-register modes: read/write, read-only (hardware-driven) and write-1-to-clear (hardware-set sticky status).
- Adds byte strobes, out-of-range error responses, independent AW/W arrival and full backpressure.
- Sits behind the AXI interconnect in block designs; driven in simulation by the Xilinx AXI VIP master.

---
 rtl/axi_lite_regbank.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with per-register RW, read-only (hardware-driven)
// and write-1-to-clear sticky status modes, byte strobes and out-of-range SLVERR.
module axi_lite_regbank #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 8,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [63:0] RO_MASK    = 64'h40,
    parameter logic [63:0] W1C_MASK   = 64'h80
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic                           irq
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  irq_q;

    logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_nxt [NUM_REGS];

    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  commit;
    logic                  ar_fire;
    logic [DATA_WIDTH-1:0] strb_bits;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [1:0]            rd_resp;
    logic                  irq_nxt;

    assign wr_idx      = aw_addr_q[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx      = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_in_range = 32'(wr_idx) < NUM_REGS;
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;

    // A commit may land in the same cycle the previous B beat is accepted.
    assign commit  = aw_held && w_held && (!bvalid_q || BREADY);
    assign ARREADY = !rvalid_q || RREADY;
    assign ar_fire = ARVALID && ARREADY;

    assign AWREADY = !aw_held;
    assign WREADY  = !w_held;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign irq     = irq_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        strb_bits = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            strb_bits[b*8 +: 8] = {8{w_strb_q[b]}};
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = commit && (wr_idx == IDX_WIDTH'(i));
        end
    end

    // Next-state of every register: bus write effect first, then hardware set (set wins).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_nxt[i] = regs[i];
            if (RO_MASK[i]) begin
                reg_nxt[i] = '0;
            end else if (W1C_MASK[i]) begin
                if (wr_sel[i]) begin
                    reg_nxt[i] = regs[i] & ~(w_data_q & strb_bits);
                end
                reg_nxt[i] = reg_nxt[i] | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (wr_sel[i]) begin
                reg_nxt[i] = (regs[i] & ~strb_bits) | (w_data_q & strb_bits);
            end
        end
    end

    always_comb begin
        irq_nxt = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (W1C_MASK[i] && !RO_MASK[i]) begin
                irq_nxt = irq_nxt | (|regs[i]);
            end
        end
    end

    // Read source uses the current (pre-write) register value.
    always_comb begin
        rd_val  = '0;
        rd_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                rd_val = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            irq_q     <= 1'b0;
            // NOTE: the register array is plain flops, not RAM, so it is reset like any other state.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (!aw_held && AWVALID) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end else if (commit) begin
                aw_held <= 1'b0;
            end

            if (!w_held && WVALID) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end else if (commit) begin
                w_held <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_resp;
            end else if (RREADY) begin
                rvalid_q <= 1'b0;
            end

            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_nxt[i];
            end
            irq_q <= irq_nxt;
        end
    end

    // Protection bits, sub-word address bits and non-applicable hw slices carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, aw_addr_q[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0],
                         hw_in, hw_set};

endmodule
